// File: rtl/retire_monitor_pkg.sv
// Shared types and constants for the retirement monitor: instruction classes,
// MIPS opcode/funct encodings, FSM states and the debug read address map.
package retire_mon_pkg;

  // Instruction classes; the numeric order is also the class counter order
  typedef enum logic [3:0] {
    CLS_ALU_R  = 4'd0,
    CLS_MUL    = 4'd1,
    CLS_NOP    = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JUMP   = 4'd6,
    CLS_IMM    = 4'd7,
    CLS_OTHER  = 4'd8
  } retire_class_e;

  localparam int NUM_CLASS = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } mon_state_e;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'd0;
  localparam logic [5:0] OP_J        = 6'd2;
  localparam logic [5:0] OP_BEQ      = 6'd4;
  localparam logic [5:0] OP_ADDIU    = 6'd9;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_SW       = 6'd43;

  // Funct codes under OP_SPECIAL
  localparam logic [5:0] FN_NOP   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  // Counter indices; a counter's index is also its read address
  localparam int CNT_CYCLES     = 0;
  localparam int CNT_RETIRED    = 1;
  localparam int CNT_STALLS     = 2;
  localparam int CNT_FLUSHES    = 3;
  localparam int CNT_CLASS_BASE = 4;
  localparam int NUM_CNT        = CNT_CLASS_BASE + NUM_CLASS;

  // Read address map
  localparam logic [5:0] ADDR_STATUS     = 6'd13;
  localparam logic [5:0] ADDR_TRACE_BASE = 6'h20;

  // Status word bit positions
  localparam int STATUS_COUNTING_BIT = 0;
  localparam int STATUS_OVERFLOW_BIT = 1;

  // Trace entries live in the upper half of the address space
  function automatic logic is_trace_addr(input logic [5:0] addr);
    return (addr & ADDR_TRACE_BASE) != 6'd0;
  endfunction

endpackage

// File: rtl/retire_monitor_if.sv
// Retirement bus plus debug read port between the core (master) and the
// retirement monitor (slave).
interface retire_monitor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             retire_valid;
  logic [5:0]       retire_op;
  logic [5:0]       retire_funct;
  logic [PC_W-1:0]  retire_pc;
  logic             stall;
  logic             flush;
  logic             rd_req;
  logic [5:0]       rd_addr;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output retire_valid, retire_op, retire_funct, retire_pc, stall, flush,
    output rd_req, rd_addr,
    input  rd_valid, rd_data
  );

  modport slave (
    input  retire_valid, retire_op, retire_funct, retire_pc, stall, flush,
    input  rd_req, rd_addr,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/retire_monitor_classifier.sv
// Combinational decode of a retiring instruction's opcode/funct into one of
// the monitor's instruction classes.
module retire_classifier
  import retire_mon_pkg::*;
(
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  output retire_class_e cls
);

  // Anything not explicitly recognised falls into CLS_OTHER
  always_comb begin
    cls = CLS_OTHER;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SRL: cls = CLS_ALU_R;
          FN_MULTU, FN_MFHI, FN_MFLO:                    cls = CLS_MUL;
          FN_NOP:                                        cls = CLS_NOP;
          default:                                       cls = CLS_OTHER;
        endcase
      end
      OP_SPECIAL2: cls = CLS_MUL;
      OP_LW:       cls = CLS_LOAD;
      OP_SW:       cls = CLS_STORE;
      OP_BEQ:      cls = CLS_BRANCH;
      OP_J:        cls = CLS_JUMP;
      OP_ADDIU:    cls = CLS_IMM;
      default:     cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/retire_monitor.sv
// Retirement monitor for the pipelined MIPS core's writeback stage.
// Counts cycles, retires, stalls, flushes and per-class retires with
// saturating counters, and exposes them through a registered read port.
// Optional feature: define RETIRE_TRACE_EN to add a HIST_DEPTH-entry ring of
// retired PCs readable at 0x20+i (0 = newest); otherwise those reads return 0.
module retire_monitor
  import retire_mon_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32,
  parameter int HIST_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  retire_monitor_if.slave  bus,
  output logic             counting,
  output logic             overflow
);

  mon_state_e       state_q, state_d;
  retire_class_e    cls;
  logic             retire_ok;
  logic             count_en;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic             overflow_q;
  logic [CNT_W-1:0] trace_word;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  retire_classifier u_classifier (
    .op    (bus.retire_op),
    .funct (bus.retire_funct),
    .cls   (cls)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: clear holds the state, start+stop together is a no-op
  always_comb begin
    state_d = state_q;
    if (!clear) begin
      case (state_q)
        ST_IDLE:  if (start && !stop) state_d = ST_COUNT;
        ST_COUNT: if (stop && !start) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    counting = (state_q == ST_COUNT);
  end

  assign retire_ok = bus.retire_valid && !bus.stall && !bus.flush;
  assign count_en  = counting && !clear;

  // Per-counter increment requests and saturation detection for this cycle
  always_comb begin
    inc = '0;
    inc[CNT_CYCLES]  = 1'b1;
    inc[CNT_RETIRED] = retire_ok;
    inc[CNT_STALLS]  = bus.stall;
    inc[CNT_FLUSHES] = bus.flush;
    for (int c = 0; c < NUM_CLASS; c++) begin
      inc[CNT_CLASS_BASE + c] = retire_ok && (cls == retire_class_e'(c));
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      at_max[i] = &cnt_q[i];
    end
    sat_hit = |(inc & at_max);
  end

  // Saturating counters and sticky overflow; clear wins over counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      overflow_q <= 1'b0;
    end else if (count_en) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i] && !at_max[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (sat_hit) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

`ifdef RETIRE_TRACE_EN
  localparam int PTR_W = $clog2(HIST_DEPTH);

  logic [PC_W-1:0]  ring_q [HIST_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] trace_slot;

  // PC ring: ptr_q is the next slot to write, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
      ptr_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
      ptr_q <= '0;
    end else if (count_en && retire_ok) begin
      ring_q[ptr_q] <= bus.retire_pc;
      ptr_q         <= ptr_q + 1'b1;
    end
  end

  // Entry i is i slots behind the most recent write
  always_comb begin
    trace_word = '0;
    trace_slot = ptr_q - PTR_W'(1) - bus.rd_addr[PTR_W-1:0];
    if (int'(bus.rd_addr[4:0]) < HIST_DEPTH) begin
      trace_word = CNT_W'(ring_q[trace_slot]);
    end
  end
`else
  // Without the ring the PC and ring geometry are intentionally ignored
  logic unused_trace;
  assign unused_trace = ^{bus.retire_pc, PC_W[0], HIST_DEPTH[0]};
  assign trace_word   = '0;
`endif

  // Read address decode over counters, status word and trace entries
  always_comb begin
    rd_mux = '0;
    if (is_trace_addr(bus.rd_addr)) begin
      rd_mux = trace_word;
    end else if (int'(bus.rd_addr) < NUM_CNT) begin
      rd_mux = cnt_q[bus.rd_addr[3:0]];
    end else if (bus.rd_addr == ADDR_STATUS) begin
      rd_mux[STATUS_OVERFLOW_BIT] = overflow_q;
      rd_mux[STATUS_COUNTING_BIT] = counting;
    end
  end

  // Registered read port: captures pre-update values in the rd_req cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) rd_data_q <= rd_mux;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule
